mra_frame_dma: RTL

- Frame DMA stage directly upstream/downstream of the MRA routing core.
- Moves one 64x64 location-map frame (4 bit/cell = 2048 B = 128 beats of 128 bit) between DRAM and the core's local map SRAM over the AXI4 master port.
- LOAD fills the SRAM from DRAM before routing. STORE writes the routed map back to DRAM after routing.

---
 rtl/mra_pkg.sv | 31 +++
 rtl/mra_frame_dma.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mra_pkg.sv
// Shared types and constants for the MRA frame DMA stage.
// Holds the FSM encoding, AXI burst constants and the frame address helper.
package mra_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_WRD,
    S_WSND,
    S_B,
    S_DONE
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16B = 3'b100;
  localparam logic [7:0] LEN_FRAME = 8'd127;

  localparam logic [31:0] BASE_ADDR = 32'h0001_0000;
  localparam int unsigned FRAME_BYTES = 2048;

  function automatic logic [31:0] frame_addr(
    input logic [4:0] id,
    input logic [31:0] base = BASE_ADDR,
    input int unsigned stride = FRAME_BYTES
  );
    return base + 32'(id) * stride;
  endfunction

endpackage

// File: rtl/mra_frame_dma.sv
// Frame DMA between DRAM (AXI4 master) and the MRA local map SRAM.
// LOAD streams one 128-beat burst into SRAM; STORE reads SRAM back out.
module mra_frame_dma
  import mra_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter logic [31:0] BASE_ADDR = mra_pkg::BASE_ADDR,
  parameter int unsigned FRAME_BYTES = mra_pkg::FRAME_BYTES,
  parameter int BEATS = 128
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [4:0]            cmd_frame_id,
  output logic                  done,
  output logic                  err,

  output logic [6:0]            sram_addr,
  output logic                  sram_we,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,

  output logic [ID_WIDTH-1:0]   arid_m_inf,
  output logic [ADDR_WIDTH-1:0] araddr_m_inf,
  output logic [7:0]            arlen_m_inf,
  output logic [2:0]            arsize_m_inf,
  output logic [1:0]            arburst_m_inf,
  output logic                  arvalid_m_inf,
  input  logic                  arready_m_inf,

  input  logic [ID_WIDTH-1:0]   rid_m_inf,
  input  logic [DATA_WIDTH-1:0] rdata_m_inf,
  input  logic [1:0]            rresp_m_inf,
  input  logic                  rlast_m_inf,
  input  logic                  rvalid_m_inf,
  output logic                  rready_m_inf,

  output logic [ID_WIDTH-1:0]   awid_m_inf,
  output logic [ADDR_WIDTH-1:0] awaddr_m_inf,
  output logic [7:0]            awlen_m_inf,
  output logic [2:0]            awsize_m_inf,
  output logic [1:0]            awburst_m_inf,
  output logic                  awvalid_m_inf,
  input  logic                  awready_m_inf,

  output logic [DATA_WIDTH-1:0] wdata_m_inf,
  output logic                  wlast_m_inf,
  output logic                  wvalid_m_inf,
  input  logic                  wready_m_inf,

  input  logic [ID_WIDTH-1:0]   bid_m_inf,
  input  logic [1:0]            bresp_m_inf,
  input  logic                  bvalid_m_inf,
  output logic                  bready_m_inf
);

  localparam logic [7:0] LAST = 8'(BEATS - 1);

  state_e                  state;
  logic [7:0]              beat;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wbuf;
  logic                    err_q;
  logic                    cmd_ready_q;

  logic                    beat_over;
  logic                    accept;
  logic                    unused_ok;

  assign beat_over = beat > LAST;
  assign accept = cmd_valid && cmd_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      beat        <= '0;
      addr_q      <= '0;
      wbuf        <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      cmd_ready_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q <= ADDR_WIDTH'(frame_addr(cmd_frame_id, BASE_ADDR,
                                             FRAME_BYTES));
            err_q  <= 1'b0;
            beat   <= '0;
            state  <= cmd_write ? S_AW : S_AR;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_AR: begin
          if (arready_m_inf) state <= S_R;
        end
        S_R: begin
          if (rvalid_m_inf) begin
            // saturate one past the last beat so overruns never wrap
            if (!beat_over) beat <= beat + 8'd1;
            if (rresp_m_inf != 2'b00) err_q <= 1'b1;
            if (rlast_m_inf != (beat == LAST)) err_q <= 1'b1;
            if (rlast_m_inf) state <= S_DONE;
          end
        end
        S_AW: begin
          if (awready_m_inf) begin
            beat  <= '0;
            state <= S_WRD;
          end
        end
        S_WRD: begin
          wbuf  <= sram_rdata;
          state <= S_WSND;
        end
        S_WSND: begin
          if (wready_m_inf) begin
            if (beat == LAST) begin
              state <= S_B;
            end else begin
              beat  <= beat + 8'd1;
              state <= S_WRD;
            end
          end
        end
        S_B: begin
          if (bvalid_m_inf) begin
            if (bresp_m_inf != 2'b00) err_q <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          cmd_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // WSND prefetches beat+1 so WRD sees its word one cycle after AW/WSND
  always_comb begin
    sram_addr = '0;
    unique case (1'b1)
      (state == S_R),
      (state == S_WRD):  sram_addr = beat[6:0];
      (state == S_WSND): sram_addr = beat[6:0] + 7'd1;
      default: ;
    endcase
  end

  assign sram_we    = (state == S_R) && rvalid_m_inf && !beat_over;
  assign sram_wdata = (state == S_R) ? rdata_m_inf : '0;

  assign cmd_ready = cmd_ready_q;
  assign done      = (state == S_DONE);
  assign err       = err_q;

  assign arid_m_inf    = '0;
  assign araddr_m_inf  = addr_q;
  assign arlen_m_inf   = LEN_FRAME;
  assign arsize_m_inf  = SIZE_16B;
  assign arburst_m_inf = BURST_INCR;
  assign arvalid_m_inf = (state == S_AR);
  assign rready_m_inf  = (state == S_R);

  assign awid_m_inf    = '0;
  assign awaddr_m_inf  = addr_q;
  assign awlen_m_inf   = LEN_FRAME;
  assign awsize_m_inf  = SIZE_16B;
  assign awburst_m_inf = BURST_INCR;
  assign awvalid_m_inf = (state == S_AW);

  assign wdata_m_inf  = wbuf;
  assign wvalid_m_inf = (state == S_WSND);
  assign wlast_m_inf  = (state == S_WSND) && (beat == LAST);
  assign bready_m_inf = (state == S_B);

  assign unused_ok = ^{rid_m_inf, bid_m_inf};

endmodule
